// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory-port arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  function automatic int unsigned id_w(input int unsigned n);
    if (n <= 1) return 1;
    return $unsigned($clog2(n));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module mem_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        id         = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory command port among NUM_REQ
// requesters; one transaction in flight, completion pulse routed to its owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         addr,
  output logic                      wr_req,
  output logic                      rd_req,
  output logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata,
  input  logic                      busy,
  input  logic                      rd_rdy
);

  localparam int unsigned     ID_W     = id_w(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_req_q, wr_req_d;
  logic                rd_req_q, rd_req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_seen_q, rd_seen_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  mem_cmd_t            sel_cmd;
  logic                fin_ok, fin_abort;

  mem_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  // Mux out the winning requester's command fields
  always_comb begin
    sel_cmd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_id == ID_W'(i)) begin
        sel_cmd.we    = req_we[i];
        sel_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_cmd.wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rd_seen_d   = rd_seen_q;
    cap_d       = cap_q;
    wr_req_d    = 1'b0;
    rd_req_d    = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    fin_ok      = 1'b0;
    fin_abort   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          id_d     = pick_id;
          we_d     = sel_cmd.we;
          addr_d   = sel_cmd.addr;
          wdata_d  = sel_cmd.wdata;
          ptr_d    = (pick_id == ID_LAST) ? '0 : pick_id + ID_W'(1);
          wr_req_d = sel_cmd.we;
          rd_req_d = !sel_cmd.we;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d     = '0;
        rd_seen_d = 1'b0;
        cap_d     = '0;
        state_d   = WAIT_START;
      end
      WAIT_START: begin
        if (rd_rdy) begin
          rd_seen_d = 1'b1;
          cap_d     = rdata;
        end
        if (busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fin_abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (rd_rdy) begin
          rd_seen_d = 1'b1;
          cap_d     = rdata;
        end
        // Read data may land in the very cycle busy drops
        if (!busy && (we_q || rd_seen_q || rd_rdy)) begin
          fin_ok = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          fin_abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin_ok || fin_abort) begin
      state_d     = IDLE;
      rsp_valid_d = NUM_REQ'(1) << id_q;
      rsp_err_d   = fin_abort;
      rsp_rdata_d = (fin_abort || we_q) ? '0 : (rd_rdy ? rdata : cap_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      cnt_q       <= '0;
      rd_seen_q   <= 1'b0;
      cap_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      cnt_q       <= cnt_d;
      rd_seen_q   <= rd_seen_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Grants are meaningless while reset is asserted, so hide them
  assign req_ready = (reset && state_q == IDLE) ? pick_grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign addr      = addr_q;
  assign wr_req    = wr_req_q;
  assign rd_req    = rd_req_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (two requesters, 8-cycle timeout).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [63:0] req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata, wdata, rdata;
  logic        rsp_err, wr_req, rd_req, busy, rd_rdy;
  logic [31:0] addr;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .NUM_REQ     (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .addr      (addr),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .rd_rdy    (rd_rdy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step;
    step;
    total++;
    if ({addr, wdata, wr_req, rd_req, rsp_valid, rsp_err, rsp_rdata, req_ready} !== 55'd0) begin
      bad++;
      $display("FAIL reset_hold outs got addr=%h wdata=%h wr=%b rd=%b rv=%b err=%b rdata=%h rdy=%b exp all 0",
               addr, wdata, wr_req, rd_req, rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    reset = 1'b1;
    step;
    total++;
    if ({addr, wdata, wr_req, rd_req, rsp_valid, rsp_err, rsp_rdata, req_ready} !== 55'd0) begin
      bad++;
      $display("FAIL reset_release outs not all 0 addr=%h wr=%b rd=%b rv=%b", addr, wr_req, rd_req, rsp_valid);
    end
  endtask

  task automatic test_write;
    req_valid = 2'b01; req_we = 2'b01; req_addr[31:0] = 32'h0000_0010; req_wdata[7:0] = 8'hA5;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready got=%b exp=01", req_ready); end
    step;
    req_valid = 2'b00;
    total++;
    if ({wr_req, rd_req} !== 2'b10) begin bad++; $display("FAIL wr_strobe got wr/rd=%b%b exp=10", wr_req, rd_req); end
    total++;
    if (addr !== 32'h10 || wdata !== 8'hA5) begin
      bad++; $display("FAIL wr_cmd got addr=%h wdata=%h exp 00000010 a5", addr, wdata);
    end
    step;
    total++;
    if ({wr_req, rd_req} !== 2'b00) begin bad++; $display("FAIL wr_strobe_drop got=%b%b exp=00", wr_req, rd_req); end
    busy = 1'b1;
    step;
    step;
    step;
    busy = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_early_rsp got=%b exp=00", rsp_valid); end
    step;
    total++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
      bad++; $display("FAIL wr_rsp got rv=%b err=%b rdata=%h exp 01 0 00", rsp_valid, rsp_err, rsp_rdata);
    end
    total++;
    if (addr !== 32'h10 || wdata !== 8'hA5) begin bad++; $display("FAIL wr_cmd_hold got addr=%h wdata=%h", addr, wdata); end
    step;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_rsp_width got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_read;
    req_valid = 2'b10; req_we = 2'b00; req_addr[63:32] = 32'h0000_0200;
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL rd_ready got=%b exp=10", req_ready); end
    step;
    req_valid = 2'b00;
    total++;
    if ({wr_req, rd_req} !== 2'b01 || addr !== 32'h200) begin
      bad++; $display("FAIL rd_strobe got wr/rd=%b%b addr=%h exp 01 00000200", wr_req, rd_req, addr);
    end
    step;
    busy = 1'b1;
    total++;
    if (rd_req !== 1'b0) begin bad++; $display("FAIL rd_pulse_width got=%b exp=0", rd_req); end
    step;
    rd_rdy = 1'b1; rdata = 8'h3C;
    step;
    rd_rdy = 1'b0; rdata = 8'h00;
    total++;
    if (rd_req !== 1'b0) begin bad++; $display("FAIL rd_no_repeat got=%b exp=0", rd_req); end
    step;
    busy = 1'b0;
    step;
    total++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rd_rsp got rv=%b rdata=%h err=%b exp 10 3c 0", rsp_valid, rsp_rdata, rsp_err);
    end
    step;
  endtask

  task automatic test_round_robin;
    int         ngr  = 0;
    int         nrsp = 0;
    int         last = 0;
    logic       prev = 1'b0;
    logic [1:0] exp_oh;
    req_we = 2'b00; req_addr = {32'h0000_0B00, 32'h0000_0A00}; req_valid = 2'b11;
    for (int c = 0; c < 60 && nrsp < 4; c++) begin
      busy   = prev;
      rd_rdy = prev;
      rdata  = prev ? 8'(8'h4F + ngr) : 8'h00;
      if (ngr >= 4) req_valid = 2'b00;
      #1;
      if (rsp_valid !== 2'b00) begin
        exp_oh = (nrsp % 2 == 0) ? 2'b01 : 2'b10;
        total++;
        if (rsp_valid !== exp_oh || rsp_rdata !== 8'(8'h50 + nrsp) || rsp_err !== 1'b0) begin
          bad++; $display("FAIL rr_rsp%0d got rv=%b rdata=%h err=%b exp %b %h 0",
                          nrsp, rsp_valid, rsp_rdata, rsp_err, exp_oh, 8'(8'h50 + nrsp));
        end
        nrsp++;
      end
      if (req_ready !== 2'b00) begin
        exp_oh = (ngr % 2 == 0) ? 2'b01 : 2'b10;
        total++;
        if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", ngr, req_ready, exp_oh); end
        if (ngr > 0) begin
          total++;
          if (c - last != 4) begin bad++; $display("FAIL rr_spacing%0d got=%0d exp=4", ngr, c - last); end
        end
        last = c;
        ngr++;
      end
      prev = wr_req | rd_req;
      step;
    end
    busy = 1'b0; rd_rdy = 1'b0; rdata = 8'h00; req_valid = 2'b00;
    total++;
    if (ngr != 4 || nrsp != 4) begin bad++; $display("FAIL rr_count got grants=%0d rsps=%0d exp 4 4", ngr, nrsp); end
  endtask

  task automatic test_timeout;
    req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h0000_0300;
    rdata = 8'hFF;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL to_ready got=%b exp=01", req_ready); end
    step;
    req_valid = 2'b00;
    total++;
    if (rd_req !== 1'b1) begin bad++; $display("FAIL to_strobe got=%b exp=1", rd_req); end
    for (int k = 2; k <= 9; k++) begin
      step;
      total++;
      if (rsp_valid !== 2'b00) begin bad++; $display("FAIL to_early issue+%0d got=%b exp=00", k, rsp_valid); end
    end
    step;
    total++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
      bad++; $display("FAIL to_rsp got rv=%b err=%b rdata=%h exp 01 1 00", rsp_valid, rsp_err, rsp_rdata);
    end
    rdata = 8'h00;
    step;
  endtask

  task automatic test_same_cycle;
    req_valid = 2'b10; req_we = 2'b00; req_addr[63:32] = 32'h0000_0400;
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL sc_ready got=%b exp=10", req_ready); end
    step;
    req_valid = 2'b00;
    step;
    busy = 1'b1;
    step;
    step;
    busy = 1'b0; rd_rdy = 1'b1; rdata = 8'h77;
    #1;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL sc_early got=%b exp=00", rsp_valid); end
    step;
    rd_rdy = 1'b0; rdata = 8'h00;
    total++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h77 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL sc_rsp got rv=%b rdata=%h err=%b exp 10 77 0", rsp_valid, rsp_rdata, rsp_err);
    end
    step;
  endtask

  task automatic test_reset_mid;
    req_valid = 2'b01; req_we = 2'b01; req_addr[31:0] = 32'h0000_0044; req_wdata[7:0] = 8'h5A;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_ready got=%b exp=01", req_ready); end
    step;
    req_valid = 2'b00;
    step;
    busy = 1'b1;
    step;
    reset = 1'b0;
    step;
    reset = 1'b1; busy = 1'b0;
    #1;
    total++;
    if ({addr, wdata, wr_req, rd_req, rsp_valid, rsp_err, rsp_rdata, req_ready} !== 55'd0) begin
      bad++; $display("FAIL rm_outs got addr=%h wdata=%h wr=%b rd=%b rv=%b err=%b rdy=%b exp all 0",
                      addr, wdata, wr_req, rd_req, rsp_valid, rsp_err, req_ready);
    end
    step;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rm_no_rsp got=%b exp=00", rsp_valid); end
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_ptr_reset got=%b exp=01", req_ready); end
    step;
    req_valid = 2'b00;
    step;
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rdata = '0; busy = 1'b0; rd_rdy = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_round_robin;
    test_timeout;
    test_same_cycle;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired before end of tests");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single byte-wide memory command port (addr/wr_req/rd_req/wdata/rdata/busy/rd_rdy) between NUM_REQ requesters.
- Accepts one request at a time, issues it as a one-cycle strobe, then tracks busy and rd_rdy to completion.
- Returns a completion pulse, plus read data, to the requester that owns the transaction.
- Sits between the client blocks and the HyperRAM controller's memory interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYC, 255, max cycles spent in each wait state before abort (1..65535)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request pending; held until req_ready
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*32  packed addresses; requester i uses bits [32i+31:32i]
- req_wdata  in  NUM_REQ*8  packed write bytes
- req_ready  out  NUM_REQ  one-hot accept pulse (combinational)
- rsp_valid  out  NUM_REQ  one-hot completion pulse, one cycle
- rsp_rdata  out  8  read byte, valid with rsp_valid for a read
- rsp_err  out  1  timeout flag, valid with rsp_valid
- addr  out  32  memory address (registered)
- wr_req  out  1  memory write strobe (registered)
- rd_req  out  1  memory read strobe (registered)
- wdata  out  8  memory write byte (registered)
- rdata  in  8  memory read byte, valid when rd_rdy=1
- busy  in  1  memory busy
- rd_rdy  in  1  memory read-data pulse

Behaviour:
- Reset: sampled at posedge with reset=0. All of the following clear to 0: outputs, state (IDLE), pointer (requester 0 has top priority), timeout counter, rd_seen.
- Reset mid-transaction: the transaction is abandoned and no rsp_valid is generated. Requesters must re-request.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from ptr upward with wrap.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At that edge: latch winner id, we, addr and wdata; set ptr = (winner+1) mod NUM_REQ; go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE (one cycle):
  - addr/wdata hold the latched values.
  - Exactly one of wr_req or rd_req is 1, per the latched we.
  - Clear the counter; go to WAIT_START.
  - addr/wdata keep their values until the next ISSUE. Strobes return to 0 after ISSUE.
- WAIT_START:
  - busy=1: go to WAIT_DONE.
  - Counter reaching TIMEOUT_CYC-1: abort.
  - Otherwise increment the counter.
  - rd_rdy=1 in this state sets rd_seen and captures rdata.
- WAIT_DONE:
  - rd_rdy=1: set rd_seen and capture rdata. This includes rd_rdy arriving in the same cycle busy falls.
  - Done when busy=0 and (we=1 or rd_seen=1, or rd_rdy=1 in this cycle).
  - On done: go to IDLE. The next cycle gives rsp_valid[owner]=1, rsp_rdata = captured byte (writes: 0x00), rsp_err=0.
  - Counter reaching TIMEOUT_CYC-1 before done: abort. The counter is cleared on entry to this state.
- Abort: go to IDLE. Next cycle gives rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0x00.
- rsp_valid is registered. In the same cycle that rsp_valid is high, IDLE may already grant a new request.
- Throughput: at most one transaction in flight. Minimum accept-to-accept spacing is 4 cycles (IDLE, ISSUE, WAIT_START, WAIT_DONE).
- Strobes are never asserted outside ISSUE. wr_req and rd_req are never high together.
- A requester that drops req_valid before req_ready is simply not served. A requester that holds req_valid after req_ready issues a new request.

Decomposition:
- Shared package mem_arb_pkg:
  - ADDR_W=32, DATA_W=8
  - state enum {IDLE, ISSUE, WAIT_START, WAIT_DONE}
  - function clog2-based ID_W
- Sub-module mem_rr_pick: combinational round-robin pick.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, id, any.
- The top module holds the FSM, latches, counter and response registers.

Test Plan:
- Write: req0 writes addr 0x0000_0010, wdata 0xA5. Memory holds busy high for 3 cycles. Required: req_ready[0] at T; wr_req=1 at T+1 only, with addr 0x10 and wdata 0xA5; rsp_valid[0] one cycle after busy falls; rsp_err=0.
- Read: req1 reads addr 0x0000_0200. Memory pulses rd_rdy with rdata=0x3C while busy=1. Required: rd_req single pulse; rsp_valid[1]=1 with rsp_rdata=0x3C.
- Both requesters held valid for 4 transactions. Required grant order after reset: 0, 1, 0, 1; never two consecutive grants to the same requester.
- Timeout: TIMEOUT_CYC=8, read issued, busy never rises. Required: rsp_valid[owner] with rsp_err=1 and rsp_rdata=0x00, 9 cycles after ISSUE.
- rd_rdy arrives with rdata 0x77 in the same cycle busy falls. Required: completes normally with rsp_rdata=0x77 and no timeout.
- reset=0 for one cycle during WAIT_DONE. Required: all outputs 0 next cycle; no rsp_valid for the aborted transaction; with both requesters valid, the next grant goes to requester 0.
